// File: rtl/dsp_mem_pkg.sv
// Shared types and constants for the dsp coefficient/sample memory arbiter.
// The requester id is sized for the largest supported requester count (8).
package dsp_mem_pkg;

  localparam int unsigned MEM_ADDR_W = 6;
  localparam int unsigned MEM_DATA_W = 14;
  localparam int unsigned MAX_REQ    = 8;
  localparam int unsigned REQ_ID_W   = 3;

  typedef logic [REQ_ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/dsp_mem_arbiter_rr_pick.sv
// Combinational round-robin selector: a valid, eligible lock owner wins outright,
// otherwise the first eligible requester at or above the pointer, wrapping to 0.
module rr_pick
  import dsp_mem_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               lock_valid,
  input  req_id_t            lock_id,
  output req_id_t            winner,
  output logic               any_valid
);

  logic    hi_found;
  logic    lo_found;
  logic    lock_hit;
  req_id_t hi_id;
  req_id_t lo_id;

  // Downward scan leaves the lowest matching index in hi_id / lo_id.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    lock_hit = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lo_found = 1'b1;
        lo_id    = req_id_t'(i);
        if (i >= int'(ptr)) begin
          hi_found = 1'b1;
          hi_id    = req_id_t'(i);
        end
        if (lock_valid && (lock_id == req_id_t'(i))) begin
          lock_hit = 1'b1;
        end
      end
    end

    if (lock_hit) begin
      winner = lock_id;
    end else if (hi_found) begin
      winner = hi_id;
    end else begin
      winner = lo_id;
    end
    any_valid = lo_found;
  end

endmodule

// File: rtl/dsp_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between dsp instances,
// with burst lock and tagged read-data return after a fixed memory latency.
module dsp_mem_arbiter
  import dsp_mem_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = MEM_ADDR_W,
  parameter int unsigned DATA_W  = MEM_DATA_W,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_din,
  input  logic [DATA_W-1:0]         mem_dout
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr_q;
  logic               lock_valid_q;
  req_id_t            lock_id_q;
  req_id_t            gnt_id_q;
  rd_tag_t            tag_q [MEM_LAT];

  logic [NUM_REQ-1:0] eligible;
  req_id_t            winner;
  logic               any_valid;
  logic [NUM_REQ-1:0] win_onehot;
  logic               sel_we;
  logic               sel_lock;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               owner_req;
  logic [PTR_W-1:0]   ptr_inc;

  // A requester seeing its grant this cycle must not be re-granted on held req.
  assign eligible = req & ~gnt;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .eligible   (eligible),
    .ptr        (ptr_q),
    .lock_valid (lock_valid_q),
    .lock_id    (lock_id_q),
    .winner     (winner),
    .any_valid  (any_valid)
  );

  always_comb begin
    sel_we     = 1'b0;
    sel_lock   = 1'b0;
    sel_addr   = '0;
    sel_wdata  = '0;
    win_onehot = '0;
    owner_req  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == req_id_t'(i)) begin
        sel_we        = we[i];
        sel_lock      = lock[i];
        sel_addr      = addr[i*ADDR_W +: ADDR_W];
        sel_wdata     = wdata[i*DATA_W +: DATA_W];
        win_onehot[i] = any_valid;
      end
      if (lock_id_q == req_id_t'(i)) begin
        owner_req = req[i];
      end
    end
    ptr_inc = (winner == req_id_t'(NUM_REQ - 1)) ? '0 : PTR_W'(winner + 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt          <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_din      <= '0;
      ptr_q        <= '0;
      lock_valid_q <= 1'b0;
      lock_id_q    <= '0;
      gnt_id_q     <= '0;
      for (int i = 0; i < MEM_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      gnt    <= win_onehot;
      mem_en <= any_valid;
      mem_we <= any_valid & sel_we;
      if (any_valid) begin
        mem_addr <= sel_addr;
        mem_din  <= sel_wdata;
        gnt_id_q <= winner;
        if (sel_lock) begin
          lock_valid_q <= 1'b1;
          lock_id_q    <= winner;
        end else begin
          lock_valid_q <= 1'b0;
          ptr_q        <= ptr_inc;
        end
      end else if (lock_valid_q && !owner_req) begin
        lock_valid_q <= 1'b0;
      end

      // Stage 0 tags the access currently on the memory port.
      tag_q[0].valid <= mem_en & ~mem_we;
      tag_q[0].id    <= gnt_id_q;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    rvalid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tag_q[MEM_LAT-1].valid && (tag_q[MEM_LAT-1].id == req_id_t'(i))) begin
        rvalid[i] = 1'b1;
      end
    end
    rdata = (|rvalid) ? mem_dout : '0;
  end

endmodule

// File: tb/tb_dsp_mem_arbiter.sv
// Directed bench for dsp_mem_arbiter: two-requester table (latency 1), a latency-3
// reset-flush sequence and a four-requester wrap sequence, each with its own memory.
module tb_dsp_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural memory contents: last write wins, else a fixed address pattern.
  logic        wr_valid = 1'b0;
  logic [5:0]  wr_addr  = '0;
  logic [13:0] wr_data  = '0;

  function automatic logic [13:0] rd_model(input logic [5:0] a);
    if (wr_valid && (a == wr_addr)) return wr_data;
    if (a == 6'h2A) return 14'h1234;
    return {a, 8'h5A};
  endfunction

  // DUT a: NUM_REQ=2, MEM_LAT=1
  logic [1:0]  a_req, a_we, a_lock, a_gnt, a_rvalid;
  logic [11:0] a_addr_bus;
  logic [27:0] a_wdata_bus;
  logic [13:0] a_rdata, a_din, a_dout;
  logic        a_en, a_mwe;
  logic [5:0]  a_addr;

  dsp_mem_arbiter #(.NUM_REQ(2), .ADDR_W(6), .DATA_W(14), .MEM_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst), .req(a_req), .we(a_we), .lock(a_lock), .addr(a_addr_bus),
    .wdata(a_wdata_bus), .gnt(a_gnt), .rvalid(a_rvalid), .rdata(a_rdata), .mem_en(a_en),
    .mem_we(a_mwe), .mem_addr(a_addr), .mem_din(a_din), .mem_dout(a_dout)
  );

  // DUT b: NUM_REQ=2, MEM_LAT=3
  logic [1:0]  b_req, b_gnt, b_rvalid;
  logic [13:0] b_rdata, b_din, b_dout;
  logic        b_en, b_mwe;
  logic [5:0]  b_addr;
  logic [13:0] b_p1, b_p2;

  dsp_mem_arbiter #(.NUM_REQ(2), .ADDR_W(6), .DATA_W(14), .MEM_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst), .req(b_req), .we(2'b00), .lock(2'b00), .addr({6'h11, 6'h10}),
    .wdata(28'h0), .gnt(b_gnt), .rvalid(b_rvalid), .rdata(b_rdata), .mem_en(b_en),
    .mem_we(b_mwe), .mem_addr(b_addr), .mem_din(b_din), .mem_dout(b_dout)
  );

  // DUT c: NUM_REQ=4, MEM_LAT=1
  logic [3:0]  c_req, c_gnt, c_rvalid;
  logic [13:0] c_rdata, c_din, c_dout;
  logic        c_en, c_mwe;
  logic [5:0]  c_addr;

  dsp_mem_arbiter #(.NUM_REQ(4), .ADDR_W(6), .DATA_W(14), .MEM_LAT(1)) u_dut_c (
    .clk(clk), .rst(rst), .req(c_req), .we(4'b0000), .lock(4'b0000),
    .addr({6'h2A, 6'h00, 6'h11, 6'h00}), .wdata(56'h0), .gnt(c_gnt), .rvalid(c_rvalid),
    .rdata(c_rdata), .mem_en(c_en), .mem_we(c_mwe), .mem_addr(c_addr), .mem_din(c_din),
    .mem_dout(c_dout)
  );

  always @(posedge clk) begin
    if (a_en && a_mwe) begin
      wr_valid <= 1'b1;
      wr_addr  <= a_addr;
      wr_data  <= a_din;
    end
    a_dout <= rd_model(a_addr);
    b_p1   <= rd_model(b_addr);
    b_p2   <= b_p1;
    b_dout <= b_p2;
    c_dout <= rd_model(c_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  req, we, lock;
    logic [5:0]  a0, a1;
    logic [13:0] w1;
    logic [1:0]  gnt, rv;
    logic        en, mwe;
    logic [5:0]  maddr;
    logic [13:0] din, rdata;
  } vec_t;

  vec_t tbl [23];

  logic [3:0]  c_req_s  [9];
  logic [3:0]  c_gnt_s  [9];
  logic [3:0]  c_rv_s   [9];
  logic [5:0]  c_addr_s [9];
  logic [13:0] c_rd_s   [9];

  initial begin
    //        rst   req    we     lock   a0     a1     w1
    //        gnt   rv     en     mwe    maddr  din      rdata
    tbl = '{
      '{1'b1, 2'h0, 2'h0, 2'h0, 6'h00, 6'h00, 14'h0000,
        2'h0, 2'h0, 1'b0, 1'b0, 6'h00, 14'h0000, 14'h0000},
      '{1'b0, 2'h1, 2'h0, 2'h0, 6'h2A, 6'h00, 14'h0000,
        2'h1, 2'h0, 1'b1, 1'b0, 6'h2A, 14'h0000, 14'h0000},
      '{1'b0, 2'h0, 2'h0, 2'h0, 6'h2A, 6'h00, 14'h0000,
        2'h0, 2'h1, 1'b0, 1'b0, 6'h2A, 14'h0000, 14'h1234},
      '{1'b1, 2'h3, 2'h0, 2'h0, 6'h2A, 6'h00, 14'h0000,
        2'h0, 2'h0, 1'b0, 1'b0, 6'h00, 14'h0000, 14'h0000},
      '{1'b0, 2'h3, 2'h0, 2'h0, 6'h10, 6'h11, 14'h0000,
        2'h1, 2'h0, 1'b1, 1'b0, 6'h10, 14'h0000, 14'h0000},
      '{1'b0, 2'h3, 2'h0, 2'h0, 6'h10, 6'h11, 14'h0000,
        2'h2, 2'h1, 1'b1, 1'b0, 6'h11, 14'h0000, 14'h105A},
      '{1'b0, 2'h3, 2'h0, 2'h0, 6'h10, 6'h11, 14'h0000,
        2'h1, 2'h2, 1'b1, 1'b0, 6'h10, 14'h0000, 14'h115A},
      '{1'b0, 2'h3, 2'h0, 2'h0, 6'h10, 6'h11, 14'h0000,
        2'h2, 2'h1, 1'b1, 1'b0, 6'h11, 14'h0000, 14'h105A},
      '{1'b0, 2'h0, 2'h0, 2'h0, 6'h10, 6'h11, 14'h0000,
        2'h0, 2'h2, 1'b0, 1'b0, 6'h11, 14'h0000, 14'h115A},
      '{1'b0, 2'h1, 2'h0, 2'h0, 6'h10, 6'h11, 14'h0000,
        2'h1, 2'h0, 1'b1, 1'b0, 6'h10, 14'h0000, 14'h0000},
      '{1'b0, 2'h2, 2'h2, 2'h0, 6'h10, 6'h05, 14'h3FFF,
        2'h2, 2'h1, 1'b1, 1'b1, 6'h05, 14'h3FFF, 14'h105A},
      '{1'b0, 2'h0, 2'h0, 2'h0, 6'h10, 6'h05, 14'h3FFF,
        2'h0, 2'h0, 1'b0, 1'b0, 6'h05, 14'h3FFF, 14'h0000},
      '{1'b0, 2'h3, 2'h0, 2'h0, 6'h10, 6'h05, 14'h3FFF,
        2'h1, 2'h0, 1'b1, 1'b0, 6'h10, 14'h0000, 14'h0000},
      '{1'b0, 2'h0, 2'h0, 2'h0, 6'h10, 6'h05, 14'h3FFF,
        2'h0, 2'h1, 1'b0, 1'b0, 6'h10, 14'h0000, 14'h105A},
      '{1'b0, 2'h1, 2'h0, 2'h0, 6'h05, 6'h05, 14'h3FFF,
        2'h1, 2'h0, 1'b1, 1'b0, 6'h05, 14'h0000, 14'h0000},
      '{1'b0, 2'h0, 2'h0, 2'h0, 6'h05, 6'h05, 14'h3FFF,
        2'h0, 2'h1, 1'b0, 1'b0, 6'h05, 14'h0000, 14'h3FFF},
      '{1'b0, 2'h1, 2'h0, 2'h1, 6'h2A, 6'h11, 14'h0000,
        2'h1, 2'h0, 1'b1, 1'b0, 6'h2A, 14'h0000, 14'h0000},
      '{1'b0, 2'h1, 2'h0, 2'h1, 6'h2A, 6'h11, 14'h0000,
        2'h0, 2'h1, 1'b0, 1'b0, 6'h2A, 14'h0000, 14'h1234},
      '{1'b0, 2'h3, 2'h0, 2'h1, 6'h2A, 6'h11, 14'h0000,
        2'h1, 2'h0, 1'b1, 1'b0, 6'h2A, 14'h0000, 14'h0000},
      '{1'b0, 2'h3, 2'h0, 2'h1, 6'h2A, 6'h11, 14'h0000,
        2'h2, 2'h1, 1'b1, 1'b0, 6'h11, 14'h0000, 14'h1234},
      '{1'b0, 2'h3, 2'h0, 2'h0, 6'h2A, 6'h11, 14'h0000,
        2'h1, 2'h2, 1'b1, 1'b0, 6'h2A, 14'h0000, 14'h115A},
      '{1'b0, 2'h2, 2'h0, 2'h0, 6'h2A, 6'h11, 14'h0000,
        2'h2, 2'h1, 1'b1, 1'b0, 6'h11, 14'h0000, 14'h1234},
      '{1'b0, 2'h0, 2'h0, 2'h0, 6'h2A, 6'h11, 14'h0000,
        2'h0, 2'h2, 1'b0, 1'b0, 6'h11, 14'h0000, 14'h115A}
    };

    c_req_s  = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b1010, 4'b1010, 4'b1010, 4'b0000,
                 4'b1010};
    c_gnt_s  = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0010, 4'b1000, 4'b0000,
                 4'b0010};
    c_rv_s   = '{4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0010, 4'b1000,
                 4'b0000};
    c_addr_s = '{6'h11, 6'h11, 6'h11, 6'h11, 6'h2A, 6'h11, 6'h2A, 6'h2A, 6'h11};
    c_rd_s   = '{14'h0000, 14'h115A, 14'h0000, 14'h115A, 14'h0000, 14'h1234, 14'h115A,
                 14'h1234, 14'h0000};

    rst = 1'b1;
    a_req = '0; a_we = '0; a_lock = '0; a_addr_bus = '0; a_wdata_bus = '0;
    b_req = '0;
    c_req = '0;
    @(negedge clk);

    // Two-requester table: inputs applied at negedge, outputs checked one edge later.
    for (int k = 0; k < 23; k++) begin
      rst         = tbl[k].rst;
      a_req       = tbl[k].req;
      a_we        = tbl[k].we;
      a_lock      = tbl[k].lock;
      a_addr_bus  = {tbl[k].a1, tbl[k].a0};
      a_wdata_bus = {tbl[k].w1, 14'h0000};
      @(negedge clk);
      chk($sformatf("a%0d gnt", k), 32'(a_gnt), 32'(tbl[k].gnt));
      chk($sformatf("a%0d rvalid", k), 32'(a_rvalid), 32'(tbl[k].rv));
      chk($sformatf("a%0d mem_en", k), 32'(a_en), 32'(tbl[k].en));
      chk($sformatf("a%0d mem_we", k), 32'(a_mwe), 32'(tbl[k].mwe));
      chk($sformatf("a%0d mem_addr", k), 32'(a_addr), 32'(tbl[k].maddr));
      chk($sformatf("a%0d mem_din", k), 32'(a_din), 32'(tbl[k].din));
      chk($sformatf("a%0d rdata", k), 32'(a_rdata), 32'(tbl[k].rdata));
    end
    a_req = '0;
    rst   = 1'b0;

    // Latency 3: three back-to-back reads, reset lands before the last two return.
    b_req = 2'b11;
    @(negedge clk);
    chk("b gnt1", 32'(b_gnt), 32'(2'b01));
    @(negedge clk);
    chk("b gnt2", 32'(b_gnt), 32'(2'b10));
    @(negedge clk);
    chk("b gnt3", 32'(b_gnt), 32'(2'b01));
    b_req = 2'b00;
    @(negedge clk);
    chk("b first return rvalid", 32'(b_rvalid), 32'(2'b01));
    chk("b first return rdata", 32'(b_rdata), 32'(14'h105A));
    chk("b idle mem_en", 32'(b_en), 32'(1'b0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("b rst gnt", 32'(b_gnt), 32'(2'b00));
    chk("b rst rvalid", 32'(b_rvalid), 32'(2'b00));
    chk("b rst mem_en", 32'(b_en), 32'(1'b0));
    chk("b rst mem_we", 32'(b_mwe), 32'(1'b0));
    chk("b rst mem_addr", 32'(b_addr), 32'(6'h00));
    chk("b rst mem_din", 32'(b_din), 32'(14'h0000));
    chk("b rst rdata", 32'(b_rdata), 32'(14'h0000));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("b flushed rvalid %0d", k), 32'(b_rvalid), 32'(2'b00));
    end
    b_req = 2'b11;
    @(negedge clk);
    chk("b post-reset gnt", 32'(b_gnt), 32'(2'b01));
    chk("b post-reset mem_addr", 32'(b_addr), 32'(6'h10));
    b_req = 2'b00;

    // Four requesters, only 1 and 3 active: pointer parked at 2, scan wraps.
    for (int k = 0; k < 9; k++) begin
      c_req = c_req_s[k];
      @(negedge clk);
      chk($sformatf("c%0d gnt", k), 32'(c_gnt), 32'(c_gnt_s[k]));
      chk($sformatf("c%0d rvalid", k), 32'(c_rvalid), 32'(c_rv_s[k]));
      chk($sformatf("c%0d mem_addr", k), 32'(c_addr), 32'(c_addr_s[k]));
      chk($sformatf("c%0d rdata", k), 32'(c_rdata), 32'(c_rd_s[k]));
      chk($sformatf("c%0d mem_we", k), 32'(c_mwe), 32'(1'b0));
      chk($sformatf("c%0d mem_din", k), 32'(c_din), 32'(14'h0000));
      chk($sformatf("c%0d mem_en", k), 32'(c_en), 32'(|c_gnt_s[k]));
    end
    c_req = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
